imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the CPU's 64-word instruction memory. It accepts a byte stream from the serial receiver with a valid/ready handshake. It packs little-endian bytes into 32-bit instructions, drives the instruction-memory write port, and verifies an XOR checksum. It holds the CPU in reset until a load completes without error.

## Interface
- DEPTH, 64, instruction words in memory (maximum load length)
- AW, 6, write-address width, equal to log2(DEPTH)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  incoming stream byte
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader accepts a byte this cycle
- start  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR
- mem_we  out  1  instruction-memory write strobe, one-cycle pulse
- mem_waddr  out  AW  word address of the write
- mem_wdata  out  32  instruction word to write
- cpu_hold  out  1  holds the CPU in reset while high
- done  out  1  load completed and checksum matched
- error  out  1  bad word count or checksum mismatch

## Operation
- Stream format:
  - count byte N, legal range 1..DEPTH
  - then 4·N data bytes, little-endian per word (first byte is bits [7:0])
  - then one checksum byte, equal to the XOR of all 4·N data bytes
- A byte is accepted when in_valid && in_ready at a rising edge.
- States and transitions:
  - IDLE: in_ready=1.
    - Accepted byte with N=0 or N>DEPTH → ERROR.
    - Otherwise latch N, clear the word index, byte counter and XOR accumulator → LOAD.
  - LOAD: in_ready=1.
    - Each accepted byte shifts into the word register and is XORed into the accumulator.
    - On the 4th byte of a word, register the write.
    - After the 4th byte of word N-1 → CHECK.
  - CHECK: in_ready=1.
    - Accepted byte equal to the accumulator → DONE.
    - Accepted byte not equal to the accumulator → ERROR.
  - DONE: in_ready=0, cpu_hold=0, done=1.
  - ERROR: in_ready=0, cpu_hold=1, error=1. Words already written stay in memory.
  - From DONE or ERROR, start=1 → IDLE: cpu_hold=1, done=0, error=0.
  - In IDLE, LOAD and CHECK, start is ignored.
- Word index counts 0..N-1. It never wraps, because N≤DEPTH is checked at entry.
- Gaps in in_valid are legal anywhere. State holds while no byte is accepted.

## Timing
- Reset values:
  - state IDLE, so in_ready=1
  - cpu_hold=1, done=0, error=0
  - mem_we=0, mem_waddr=0, mem_wdata=0
- Reset mid-load abandons the load immediately. A fresh stream after release starts again at address 0.
- Write timing:
  - mem_we is high for exactly the one cycle after the edge that accepts a word's 4th byte.
  - mem_waddr and mem_wdata are registered and valid in that cycle, and hold their values afterwards.
- Back-to-back bytes:
  - Sustained throughput is one byte per cycle and in_ready never drops in LOAD.
  - A word's write cycle may coincide with acceptance of the next byte, including the checksum byte.
- done and error rise in the cycle after the checksum byte is accepted. cpu_hold falls in that same cycle when the checksum matches.
- ERROR on a bad count is entered the cycle after the count byte is accepted. No write occurs.
- start and in_valid high together in DONE or ERROR: start wins. The byte is not accepted because in_ready=0. The next cycle is in IDLE with in_ready=1.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid to in_ready.

## Structure
- Shared package imem_loader_pkg holds:
  - the state encoding (IDLE, LOAD, CHECK, DONE, ERROR)
  - DEPTH and AW defaults
  - the byte-per-word constant (4)
- Single module, no sub-module. Byte packing and XOR accumulation are small enough to keep inline.
- mem_* ports connect to the write port of the dual-port instruction memory. The CPU keeps the combinational read port.

## Test plan
- Two-word load:
  - Stream 02, 93 01 F0 00, 93 00 40 01, B0, with no gaps.
  - Expect mem_we pulses with addr 0 = 0x00F00193 and addr 1 = 0x01400093.
  - Expect done=1, cpu_hold=0 and error=0 one cycle after B0 is accepted.
- Bad checksum: same stream ending in B1 → both writes still occur, then error=1, cpu_hold=1, done=0. start → IDLE, flags cleared.
- Bad count:
  - Count 00 → error=1 next cycle, no mem_we, in_ready=0.
  - Count 41 (65) → same result.
- Full depth: count 40 (64), 256 bytes with random in_valid gaps → 64 writes, last at addr 63, done=1 when the checksum matches.
- Reset mid-load:
  - rst_n low after 6 data bytes → all outputs at reset values.
  - The two-word stream after release completes, with the first write at addr 0.
- Simultaneous events in DONE: start and in_valid (byte 02) together → byte not accepted. The next cycle is IDLE with in_ready=1, and a repeated 02 is accepted as the count.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the instruction-memory loader
package imem_loader_pkg;

    localparam int DEPTH_DEF      = 64;
    localparam int AW_DEF         = 6;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a counted little-endian byte stream into instruction words, verifies XOR checksum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          start,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] word_idx_q, word_idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    xor_q, xor_d;
    logic [31:0]   word_q, word_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    logic accept;
    logic byte_last;
    logic word_last;
    logic [31:0] word_shifted;

    // Status outputs are pure state decodes so in_ready never depends on in_valid.
    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign cpu_hold  = (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

    assign accept       = in_valid && in_ready;
    assign byte_last    = (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_last    = ({1'b0, word_idx_q} == (count_q - (AW+1)'(1)));
    assign word_shifted = {in_data, word_q[31:8]};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        xor_d       = xor_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if ((in_data == 8'd0) || (int'(in_data) > DEPTH)) begin
                        state_d = ST_ERROR;
                    end else begin
                        count_d    = in_data[AW:0];
                        word_idx_d = '0;
                        byte_cnt_d = '0;
                        xor_d      = '0;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    word_d     = word_shifted;
                    xor_d      = xor_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_last) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_idx_q;
                        mem_wdata_d = word_shifted;
                        if (word_last) begin
                            state_d = ST_CHECK;
                        end else begin
                            word_idx_d = word_idx_q + AW'(1);
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            xor_q       <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            xor_q       <= xor_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [5:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks;
    int failures;

    int          wr_n;
    logic [5:0]  wr_a [0:511];
    logic [31:0] wr_d [0:511];

    logic [7:0]  stream [$];
    logic [31:0] exp_words [0:63];

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial wr_n = 0;
    always @(negedge clk) begin
        if (mem_we && wr_n < 512) begin
            wr_a[wr_n] = mem_waddr;
            wr_d[wr_n] = mem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        tries = 0;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int gapmax);
        foreach (stream[i]) send_byte(stream[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
    endtask

    task automatic load_two_word(input logic [7:0] csum);
        stream = '{8'h02, 8'h93, 8'h01, 8'hF0, 8'h00, 8'h93, 8'h00, 8'h40, 8'h01, csum};
        send_stream(0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int base;
        logic [7:0] x;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // two-word load, no gaps
        base = wr_n;
        load_two_word(8'hB0);
        check("tw_done", 32'(done), 32'd1);
        check("tw_hold", 32'(cpu_hold), 32'd0);
        check("tw_err", 32'(error), 32'd0);
        check("tw_ready", 32'(in_ready), 32'd0);
        check("tw_nwr", 32'(wr_n - base), 32'd2);
        check("tw_a0", 32'(wr_a[base]), 32'd0);
        check("tw_d0", wr_d[base], 32'h00F00193);
        check("tw_a1", 32'(wr_a[base+1]), 32'd1);
        check("tw_d1", wr_d[base+1], 32'h01400093);
        check("tw_hold_addr", 32'(mem_waddr), 32'd1);
        check("tw_hold_data", mem_wdata, 32'h01400093);

        // start and in_valid together in DONE: start wins, byte not taken
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h02;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("sim_ready", 32'(in_ready), 32'd1);
        check("sim_done", 32'(done), 32'd0);
        check("sim_hold", 32'(cpu_hold), 32'd1);
        base = wr_n;
        load_two_word(8'hB0);
        check("sim_reload_done", 32'(done), 32'd1);
        check("sim_reload_nwr", 32'(wr_n - base), 32'd2);
        check("sim_reload_a0", 32'(wr_a[base]), 32'd0);
        pulse_start();

        // bad checksum
        base = wr_n;
        load_two_word(8'hB1);
        check("bc_err", 32'(error), 32'd1);
        check("bc_hold", 32'(cpu_hold), 32'd1);
        check("bc_done", 32'(done), 32'd0);
        check("bc_nwr", 32'(wr_n - base), 32'd2);
        check("bc_d1", wr_d[base+1], 32'h01400093);
        pulse_start();
        check("bc_clr_err", 32'(error), 32'd0);
        check("bc_clr_ready", 32'(in_ready), 32'd1);

        // bad counts
        base = wr_n;
        send_byte(8'h00, 0);
        check("c0_err", 32'(error), 32'd1);
        check("c0_ready", 32'(in_ready), 32'd0);
        check("c0_we", 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        check("c0_nwr", 32'(wr_n - base), 32'd0);
        pulse_start();
        send_byte(8'h41, 0);
        check("c65_err", 32'(error), 32'd1);
        check("c65_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("c65_nwr", 32'(wr_n - base), 32'd0);
        pulse_start();

        // full depth with random gaps
        stream = '{8'h40};
        x = 8'h00;
        for (int w = 0; w < 64; w++) begin
            exp_words[w] = $urandom;
            for (int k = 0; k < 4; k++) begin
                stream.push_back(exp_words[w][8*k +: 8]);
                x = x ^ exp_words[w][8*k +: 8];
            end
        end
        stream.push_back(x);
        base = wr_n;
        send_stream(2);
        check("fd_done", 32'(done), 32'd1);
        check("fd_nwr", 32'(wr_n - base), 32'd64);
        for (int w = 0; w < 64; w++) begin
            check($sformatf("fd_a%0d", w), 32'(wr_a[base+w]), 32'(w));
            check($sformatf("fd_d%0d", w), wr_d[base+w], exp_words[w]);
        end
        pulse_start();

        // reset mid-load after 6 data bytes
        stream = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_stream(0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_n;
        load_two_word(8'hB0);
        check("mid_done", 32'(done), 32'd1);
        check("mid_nwr", 32'(wr_n - base), 32'd2);
        check("mid_a0", 32'(wr_a[base]), 32'd0);
        check("mid_d0", wr_d[base], 32'h00F00193);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
